spi_cmd_router: RTL and testbench

Frame router that sits on the AXI-Stream byte output of the SPI receive path. It parses a length-prefixed command framing (opcode, length, payload) from the single upstream stream and dispatches each payload to one of NUM_DEST downstream AXI-Stream sinks. Malformed frames are dropped or terminated cleanly, and errors and completed frames are counted. It is the scheduler that shares the SPI link between the design's command consumers.

---
 rtl/spi_cmd_router.sv | 271 +++++++++++++++++++++++++++
 tb/tb_spi_cmd_router.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_router.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_router
// Purpose  : Parses length-prefixed command frames (opcode, LEN, payload) from
//            the SPI receive byte stream and forwards each payload to one of
//            NUM_DEST AXI-Stream sinks. Malformed frames are dropped or
//            terminated cleanly. Completed frames and errors are counted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   axi_aclk / axi_areset : clock, synchronous active-high reset
//   s_axis_*              : upstream byte stream (tlast = end of SPI transaction)
//   m_axis_tdata/tlast    : payload byte shared by all sinks
//   m_axis_tvalid         : one-hot valid, bit = destination sink
//   m_axis_tready         : per-sink ready
//   busy                  : parser not idle
//   frame_count           : completed frames (wraps)
//   err_count             : errors (saturates at 0xFFFF)
//   err_code / err_pulse  : last error code (1 bad dest, 2 short, 3 timeout)
//                           and a one-cycle strobe per error
// ============================================================================
module spi_cmd_router #(
  parameter int NUM_DEST       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic [7:0]          s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [7:0]          m_axis_tdata,
  output logic [NUM_DEST-1:0] m_axis_tvalid,
  input  logic [NUM_DEST-1:0] m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic [15:0]         frame_count,
  output logic [15:0]         err_count,
  output logic [1:0]          err_code,
  output logic                err_pulse
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DISCARD = 3'd3,
    ST_FLUSH   = 3'd4
  } state_t;

  localparam logic [4:0]  C_NUM_DEST   = 5'(NUM_DEST);
  localparam logic [15:0] C_TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  ERR_NONE     = 2'd0;
  localparam logic [1:0]  ERR_BAD_DEST = 2'd1;
  localparam logic [1:0]  ERR_SHORT    = 2'd2;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'd3;

  state_t      state_q, state_d;
  logic [3:0]  dest_q, dest_d;
  logic [7:0]  cnt_q, cnt_d;          // payload bytes still expected
  logic [15:0] tmo_q, tmo_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic [3:0]  out_dest_q, out_dest_d; // dest of the byte held, not of the current frame
  logic [15:0] frame_count_q;
  logic [15:0] err_count_q;
  logic [1:0]  err_code_q;
  logic        err_pulse_q;

  logic [15:0] w_sink_ready;
  logic        w_out_ready;
  logic        w_out_free;
  logic        w_in_ready;
  logic        w_hs;
  logic        w_tmo_state;
  logic        w_tmo_hit;
  logic        w_err;
  logic [1:0]  w_err_code;
  logic        w_frame_done;

  // Zero-extend so any 4-bit dest can index safely whatever NUM_DEST is.
  assign w_sink_ready = 16'(m_axis_tready);
  assign w_out_ready  = w_sink_ready[out_dest_q];
  // Output register can take a byte this cycle (empty, or draining now).
  assign w_out_free   = !out_valid_q || w_out_ready;

  always_comb begin
    w_in_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_LEN, ST_DISCARD: w_in_ready = 1'b1;
      ST_PAYLOAD:                  w_in_ready = w_out_free;
      default:                     w_in_ready = 1'b0;
    endcase
  end

  assign s_axis_tready = w_in_ready && !axi_areset;
  assign w_hs          = s_axis_tvalid && s_axis_tready;

  // Only upstream starvation counts toward the timeout; a stalled sink does not.
  assign w_tmo_state = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) ||
                       (state_q == ST_DISCARD);
  assign w_tmo_hit   = w_tmo_state && !s_axis_tvalid && (tmo_q == C_TMO_LAST);

  always_comb begin
    tmo_d = tmo_q;
    if (!w_tmo_state || w_hs) begin
      tmo_d = 16'd0;
    end else if (!s_axis_tvalid) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_dest_d   = out_dest_q;
    w_err        = 1'b0;
    w_err_code   = ERR_NONE;
    w_frame_done = 1'b0;

    if (out_valid_q && w_out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_hs) begin
          dest_d = s_axis_tdata[7:4];
          if (s_axis_tlast) begin
            w_err      = 1'b1;
            w_err_code = ERR_SHORT;
          end else begin
            state_d = ST_LEN;
          end
        end
      end

      ST_LEN: begin
        if (w_hs) begin
          cnt_d = s_axis_tdata;
          // An empty frame is complete at its LEN byte, so tlast there is legal.
          if (s_axis_tdata == 8'd0) begin
            w_frame_done = 1'b1;
            state_d      = ST_IDLE;
          end else if (s_axis_tlast) begin
            w_err      = 1'b1;
            w_err_code = ERR_SHORT;
            state_d    = ST_IDLE;
          end else if ({1'b0, dest_q} >= C_NUM_DEST) begin
            w_err      = 1'b1;
            w_err_code = ERR_BAD_DEST;
            state_d    = ST_DISCARD;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_err_code = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end
      end

      ST_PAYLOAD: begin
        if (w_hs) begin
          out_valid_d = 1'b1;
          out_data_d  = s_axis_tdata;
          out_last_d  = (cnt_q == 8'd1) || s_axis_tlast;
          out_dest_d  = dest_q;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            w_frame_done = 1'b1;
            state_d      = ST_IDLE;
          end else if (s_axis_tlast) begin
            w_err      = 1'b1;
            w_err_code = ERR_SHORT;
            state_d    = ST_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_err_code = ERR_TIMEOUT;
          state_d    = ST_FLUSH;
        end
      end

      ST_DISCARD: begin
        if (w_hs) begin
          cnt_d = cnt_q - 8'd1;
          // Early tlast just ends the discard; the bad-dest error already fired.
          if ((cnt_q == 8'd1) || s_axis_tlast) begin
            state_d = ST_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_err_code = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        // Terminate the abandoned packet with a zero byte so the sink sees tlast.
        if (w_out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = 8'h00;
          out_last_d  = 1'b1;
          out_dest_d  = dest_q;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q       <= ST_IDLE;
      dest_q        <= 4'd0;
      cnt_q         <= 8'd0;
      tmo_q         <= 16'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'd0;
      out_last_q    <= 1'b0;
      out_dest_q    <= 4'd0;
      frame_count_q <= 16'd0;
      err_count_q   <= 16'd0;
      err_code_q    <= ERR_NONE;
      err_pulse_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_dest_q  <= out_dest_d;
      err_pulse_q <= w_err;
      if (w_frame_done) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (w_err) begin
        err_code_q <= w_err_code;
        if (err_count_q != 16'hFFFF) begin
          err_count_q <= err_count_q + 16'd1;
        end
      end
    end
  end

  always_comb begin
    m_axis_tvalid = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      m_axis_tvalid[i] = out_valid_q && (out_dest_q == 4'(i));
    end
  end

  assign m_axis_tdata = out_data_q;
  assign m_axis_tlast = out_last_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_count  = frame_count_q;
  assign err_count    = err_count_q;
  assign err_code     = err_code_q;
  assign err_pulse    = err_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_router
// Purpose  : Self-checking bench for spi_cmd_router. Frames are described as
//            (dest, LEN, payload, kind) items; a frame-level model derives the
//            byte sequence each sink must see and the counter/error results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_router;

  localparam int NUM_DEST = 4;
  localparam int TMO      = 8;

  localparam int K_NORMAL  = 0;  // complete frame
  localparam int K_SHORT   = 1;  // tlast on payload byte k (1..LEN-1)
  localparam int K_HDR_OP  = 2;  // tlast on opcode
  localparam int K_HDR_LEN = 3;  // tlast on LEN byte (LEN>0)
  localparam int K_TMO     = 4;  // stall after opcode (k<0) or after LEN + k bytes

  logic                axi_aclk = 1'b0;
  logic                axi_areset = 1'b1;
  logic [7:0]          s_axis_tdata = 8'd0;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tready;
  logic                s_axis_tlast = 1'b0;
  logic [7:0]          m_axis_tdata;
  logic [NUM_DEST-1:0] m_axis_tvalid;
  logic [NUM_DEST-1:0] m_axis_tready = '1;
  logic                m_axis_tlast;
  logic                busy;
  logic [15:0]         frame_count;
  logic [15:0]         err_count;
  logic [1:0]          err_code;
  logic                err_pulse;

  always #5 axi_aclk = ~axi_aclk;

  spi_cmd_router #(
    .NUM_DEST       (NUM_DEST),
    .TIMEOUT_CYCLES (TMO)
  ) u_dut (
    .axi_aclk      (axi_aclk),
    .axi_areset    (axi_areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_count   (frame_count),
    .err_count     (err_count),
    .err_code      (err_code),
    .err_pulse     (err_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [12:0] exp_q[$];   // {dest, last, data} in global delivery order
  logic [12:0] obs_q[$];
  logic [15:0] exp_frames = 16'd0;
  int          exp_errs   = 0;
  logic [1:0]  exp_code   = 2'd0;
  int          pulse_cnt  = 0;
  logic [7:0]  pl [0:255];

  int rdy_mode = 0;  // 0 all ready, 1 random, 2 sink 2 toggles, 3 none ready
  int gap_max  = 0;
  logic tog = 1'b0;

  task automatic m_err(input logic [1:0] code);
    exp_errs++;
    exp_code = code;
  endtask

  task automatic m_push(input logic [3:0] d, input logic last, input logic [7:0] data);
    exp_q.push_back({d, last, data});
  endtask

  task automatic model_frame(input logic [3:0] d, input int len, input int kind, input int k);
    bit bad;
    bad = (int'(d) >= NUM_DEST);
    case (kind)
      K_NORMAL: begin
        if (len == 0) exp_frames = exp_frames + 16'd1;
        else if (bad) m_err(2'd1);
        else begin
          for (int i = 0; i < len; i++) m_push(d, i == len - 1, pl[i]);
          exp_frames = exp_frames + 16'd1;
        end
      end
      K_SHORT: begin
        if (bad) m_err(2'd1);
        else begin
          for (int i = 0; i < k; i++) m_push(d, i == k - 1, pl[i]);
          m_err(2'd2);
        end
      end
      K_HDR_OP, K_HDR_LEN: m_err(2'd2);
      default: begin
        if (k < 0) m_err(2'd3);
        else if (bad) begin
          m_err(2'd1);
          m_err(2'd3);
        end else begin
          for (int i = 0; i < k; i++) m_push(d, 1'b0, pl[i]);
          m_push(d, 1'b1, 8'h00);
          m_err(2'd3);
        end
      end
    endcase
  endtask

  // ---------------- sink readiness ----------------
  initial begin
    forever begin
      @(posedge axi_aclk);
      #1;
      case (rdy_mode)
        0: m_axis_tready = '1;
        1: for (int i = 0; i < NUM_DEST; i++) m_axis_tready[i] = ($urandom_range(0, 2) != 0);
        2: begin
          tog = ~tog;
          m_axis_tready = '1;
          m_axis_tready[2] = tog;
        end
        default: m_axis_tready = '0;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  logic                stall_q = 1'b0;
  logic [NUM_DEST-1:0] pv_q = '0;
  logic [8:0]          pd_q = '0;

  always @(negedge axi_aclk) begin
    if (axi_areset) begin
      stall_q <= 1'b0;
    end else begin
      if (m_axis_tvalid != '0) chk("tvalid_onehot", 32'($countones(m_axis_tvalid)), 32'd1);
      if (stall_q) begin
        chk("hold_tvalid", 32'(m_axis_tvalid), 32'(pv_q));
        chk("hold_data", 32'({m_axis_tlast, m_axis_tdata}), 32'(pd_q));
      end
      for (int i = 0; i < NUM_DEST; i++) begin
        if (m_axis_tvalid[i] && m_axis_tready[i])
          obs_q.push_back({4'(i), m_axis_tlast, m_axis_tdata});
      end
      stall_q <= |(m_axis_tvalid & ~m_axis_tready);
      pv_q    <= m_axis_tvalid;
      pd_q    <= {m_axis_tlast, m_axis_tdata};
      if (err_pulse) pulse_cnt <= pulse_cnt + 1;
    end
  end

  // ---------------- drivers (all enter/leave at posedge + 1) ----------------
  task automatic send_byte(input logic [7:0] d, input logic l);
    int  g;
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    g = $urandom_range(0, gap_max);
    if (g > 0) begin
      repeat (g) @(posedge axi_aclk);
      #1;
    end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!done && waited < 2000) begin
      @(negedge axi_aclk);
      if (s_axis_tready) done = 1'b1;
      @(posedge axi_aclk);
      #1;
      waited++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("s_handshake", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge axi_aclk);
    #1;
  endtask

  task automatic do_frame(input logic [3:0] d, input int len, input int kind, input int k,
                          input logic tl_end);
    int n;
    model_frame(d, len, kind, k);
    send_byte({d, 4'($urandom_range(0, 15))}, kind == K_HDR_OP);
    if (kind == K_HDR_OP) return;
    if (kind == K_TMO && k < 0) begin
      idle(TMO + 4);
      return;
    end
    send_byte(8'(len), kind == K_HDR_LEN);
    if (kind == K_HDR_LEN) return;
    n = (kind == K_NORMAL) ? len : k;
    for (int i = 0; i < n; i++)
      send_byte(pl[i], (kind == K_SHORT && i == k - 1) ||
                       (kind == K_NORMAL && i == len - 1 && tl_end));
    if (kind == K_TMO) idle(TMO + 4);
  endtask

  task automatic checkpoint(input string tag);
    int quiet;
    int waited;
    int n;
    quiet  = 0;
    waited = 0;
    while (quiet < 3 && waited < 5000) begin
      @(negedge axi_aclk);
      if (!busy && m_axis_tvalid == '0) quiet++;
      else quiet = 0;
      waited++;
    end
    chk({tag, "_quiesce"}, 32'(quiet >= 3), 32'd1);
    chk({tag, "_s_tready_idle"}, 32'(s_axis_tready), 32'd1);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_frames));
    chk({tag, "_err_count"}, 32'(err_count), 32'(exp_errs));
    chk({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
    chk({tag, "_err_pulses"}, 32'(pulse_cnt), 32'(exp_errs));
    chk({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic rand_frame();
    logic [3:0] d;
    int len;
    int kind;
    int r;
    int k;
    d   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 40)) : int'($urandom_range(0, 6));
    r   = $urandom_range(0, 9);
    kind = (r < 6) ? K_NORMAL : (r == 6) ? K_SHORT : (r == 7) ? K_HDR_OP :
           (r == 8) ? K_HDR_LEN : K_TMO;
    k = 0;
    if (kind == K_SHORT && len < 2) kind = K_NORMAL;
    if (kind == K_HDR_LEN && len == 0) len = 1;
    if (kind == K_SHORT) k = $urandom_range(1, len - 1);
    if (kind == K_TMO) begin
      if (len == 0 || $urandom_range(0, 3) == 0) k = -1;
      else k = $urandom_range(0, len - 1);
    end
    for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
    do_frame(d, len, kind, k, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_counts", 32'({frame_count, err_count}), 32'd0);
    chk("rst_err", 32'({err_code, err_pulse}), 32'd0);
    @(posedge axi_aclk);
    #1;
    axi_areset = 1'b0;
    @(negedge axi_aclk);
    chk("post_rst_s_tready", 32'(s_axis_tready), 32'd1);
    @(posedge axi_aclk);
    #1;

    // Basic dispatch
    rdy_mode = 0; gap_max = 0;
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
    do_frame(4'd2, 3, K_NORMAL, 0, 1'b1);
    checkpoint("basic");

    // Backpressure on sink 2
    rdy_mode = 2; gap_max = 1;
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
    do_frame(4'd2, 3, K_NORMAL, 0, 1'b1);
    checkpoint("backpressure");

    // Bad dest then a good frame
    rdy_mode = 0; gap_max = 0;
    pl[0] = 8'h11; pl[1] = 8'h22;
    do_frame(4'd5, 2, K_NORMAL, 0, 1'b0);
    pl[0] = 8'h33;
    do_frame(4'd1, 1, K_NORMAL, 0, 1'b1);
    checkpoint("bad_dest");

    // Short frame
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    do_frame(4'd0, 4, K_SHORT, 2, 1'b0);
    checkpoint("short");

    // Timeout mid-payload
    pl[0] = 8'hAB;
    do_frame(4'd3, 5, K_TMO, 1, 1'b0);
    checkpoint("timeout");

    // LEN=0 followed back-to-back by a one-byte frame
    do_frame(4'd1, 0, K_NORMAL, 0, 1'b0);
    pl[0] = 8'h7E;
    do_frame(4'd0, 1, K_NORMAL, 0, 1'b1);
    checkpoint("len0_b2b");

    // Randomized groups of back-to-back frames
    for (int g = 0; g < 80; g++) begin
      rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 1;
      gap_max  = $urandom_range(0, 3);
      repeat ($urandom_range(1, 3)) rand_frame();
      checkpoint("rand");
    end

    // Reset while a payload byte is pending in the output register
    rdy_mode = 3; gap_max = 0;
    idle(2);
    send_byte(8'h20, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hAA, 1'b0);
    @(negedge axi_aclk);
    chk("midrst_pending", 32'(m_axis_tvalid), 32'h4);
    chk("midrst_busy", 32'(busy), 32'd1);
    @(posedge axi_aclk);
    #1;
    axi_areset = 1'b1;
    @(negedge axi_aclk);
    chk("midrst_s_tready", 32'(s_axis_tready), 32'd0);
    @(negedge axi_aclk);
    chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("midrst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("midrst_busy_off", 32'(busy), 32'd0);
    chk("midrst_frame_count", 32'(frame_count), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_err", 32'({err_code, err_pulse}), 32'd0);
    @(posedge axi_aclk);
    #1;
    axi_areset = 1'b0;
    rdy_mode = 0;
    @(negedge axi_aclk);
    chk("midrst_post_s_tready", 32'(s_axis_tready), 32'd1);
    idle(10);
    chk("midrst_no_output", 32'(obs_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
